ifid_hazard_ctrl: RTL

Hazard and stall sequencer for the 5-stage pipeline. It drives the write, flush and stall controls of the IF/ID register and the PC write enable, and inserts ID/EX bubbles. It resolves load-use hazards (with configurable multi-bubble depth), data-memory stalls and ID-stage branch/jump redirects. It sits beside the ID stage, between the hazard inputs from ID/EX and the memory stage and the IF/ID and PC registers.

---
 rtl/ifid_hazard_ctrl_if.sv | 39 +++
 rtl/ifid_hazard_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ifid_hazard_ctrl_if.sv
// Signal bundle between the ID-stage hazard sources and ifid_hazard_ctrl.
// All signals are level-sampled every cycle; there is no valid/ready handshake.
interface ifid_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             mem_stall_i;

  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             stall_o;
  logic             idex_bubble_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] lu_cnt_o;
  logic [CNT_W-1:0] mem_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Pipeline side: drives hazard sources, consumes controls.
  modport master (
    output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, jump_i, mem_stall_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, stall_o, idex_bubble_o,
           state_o, lu_cnt_o, mem_cnt_o, flush_cnt_o
  );

  // Hazard controller side.
  modport slave (
    input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
           branch_taken_i, jump_i, mem_stall_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, stall_o, idex_bubble_o,
           state_o, lu_cnt_o, mem_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard and stall sequencer: load-use bubbles, memory freeze, branch/jump flush.
// Define HAZARD_CTRL_PERF_EN to build the saturating performance counters.
module ifid_hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ifid_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LU_WAIT = 2'd1,
    ST_FREEZE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_NORM   = 2'd0,
    M_LU     = 2'd1,
    M_FLUSH  = 2'd2,
    M_FREEZE = 2'd3
  } mode_t;

  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

  state_t     state, state_nx;
  state_t     ret, ret_nx;
  state_t     eff;
  logic [1:0] cnt, cnt_nx;
  logic       illegal;
  logic       lu_hazard;
  logic       redirect;
  mode_t      mode;

  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       stall;
  logic       idex_bubble;

  assign lu_hazard = hz.idex_memread_i && (hz.idex_rt_i != 5'd0) &&
                     ((hz.idex_rt_i == hz.ifid_rs_i) || (hz.idex_rt_i == hz.ifid_rt_i));
  assign redirect  = hz.branch_taken_i || hz.jump_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_RUN;
      ret   <= ST_RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
      cnt   <= cnt_nx;
    end
  end

  // FREEZE leaving on this cycle behaves as the state it interrupted.
  always_comb begin
    eff     = ST_RUN;
    illegal = 1'b0;
    case (state)
      ST_RUN:     eff = ST_RUN;
      ST_LU_WAIT: eff = ST_LU_WAIT;
      ST_FREEZE:  eff = (ret == ST_LU_WAIT) ? ST_LU_WAIT : ST_RUN;
      default:    illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    cnt_nx   = cnt;
    mode     = M_NORM;
    if (illegal) begin
      state_nx = ST_RUN;
      ret_nx   = ST_RUN;
      cnt_nx   = 2'd0;
      mode     = hz.mem_stall_i ? M_FREEZE : M_NORM;
    end else if (hz.mem_stall_i) begin
      // Freeze holds cnt so the remaining bubbles resume afterwards.
      mode     = M_FREEZE;
      state_nx = ST_FREEZE;
      ret_nx   = eff;
    end else if (eff == ST_LU_WAIT) begin
      mode   = M_LU;
      ret_nx = ST_RUN;
      if (cnt <= 2'd1) begin
        state_nx = ST_RUN;
        cnt_nx   = 2'd0;
      end else begin
        state_nx = ST_LU_WAIT;
        cnt_nx   = cnt - 2'd1;
      end
    end else if (lu_hazard) begin
      mode   = M_LU;
      ret_nx = ST_RUN;
      if (LU_BUBBLES > 1) begin
        state_nx = ST_LU_WAIT;
        cnt_nx   = LU_INIT;
      end else begin
        state_nx = ST_RUN;
        cnt_nx   = 2'd0;
      end
    end else begin
      // A redirect only wins when nothing else holds ID, so it flushes exactly once.
      mode     = redirect ? M_FLUSH : M_NORM;
      state_nx = ST_RUN;
      ret_nx   = ST_RUN;
      cnt_nx   = 2'd0;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    stall       = 1'b0;
    idex_bubble = 1'b0;
    case (mode)
      M_LU: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      M_FLUSH: ifid_flush = 1'b1;
      M_FREEZE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        stall      = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz.pc_write_o    = pc_write;
  assign hz.ifid_write_o  = ifid_write;
  assign hz.ifid_flush_o  = ifid_flush;
  assign hz.stall_o       = stall;
  assign hz.idex_bubble_o = idex_bubble;
  assign hz.state_o       = state;

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] lu_cnt, mem_cnt, flush_cnt;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lu_cnt    <= '0;
      mem_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (idex_bubble && (lu_cnt != {CNT_W{1'b1}}))   lu_cnt    <= lu_cnt + 1'b1;
      if (stall && (mem_cnt != {CNT_W{1'b1}}))        mem_cnt   <= mem_cnt + 1'b1;
      if (ifid_flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.lu_cnt_o    = lu_cnt;
  assign hz.mem_cnt_o   = mem_cnt;
  assign hz.flush_cnt_o = flush_cnt;
`else
  assign hz.lu_cnt_o    = {CNT_W{1'b0}};
  assign hz.mem_cnt_o   = {CNT_W{1'b0}};
  assign hz.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule
